mult: RTL and testbench



---
 rtl/mult_pkg.sv | 13 +
 rtl/mult.sv | 80 ++++++++
 tb/tb_mult.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared widths and FSM state encoding for the sequential multiplier.
package mult_pkg;

    localparam int unsigned OP_W   = 8;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned CTR_W  = 3;

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

endpackage : mult_pkg

// File: rtl/mult.sv
// Sequential unsigned 8x8 shift-and-add multiplier, one partial product per clock.
module mult
    import mult_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [OP_W-1:0]     a_bi,
    input  logic [OP_W-1:0]     b_bi,
    input  logic                start_i,
    output logic                busy_o,
    output logic [PROD_W-1:0]   y_bo
);

    state_t              state_q, state_d;
    logic [OP_W-1:0]     a_q, a_d;
    logic [OP_W-1:0]     b_q, b_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CTR_W-1:0]    ctr_q, ctr_d;
    logic [PROD_W-1:0]   y_q, y_d;
    logic [PROD_W-1:0]   partial;

    // Next-state logic: accept in IDLE, accumulate one shifted operand per WORK cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        ctr_d   = ctr_q;
        y_d     = y_q;
        partial = b_q[ctr_q] ? ({{(PROD_W-OP_W){1'b0}}, a_q} << ctr_q) : '0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_bi;
                    b_d     = b_bi;
                    acc_d   = '0;
                    ctr_d   = '0;
                    state_d = WORK;
                end
            end
            WORK: begin
                acc_d = acc_q + partial;
                ctr_d = ctr_q + 3'd1;
                // Last bit: publish the sum including this cycle's partial product.
                if (ctr_q == 3'd7) begin
                    y_d     = acc_q + partial;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset; reset aborts any operation.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            ctr_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            ctr_q   <= ctr_d;
            y_q     <= y_d;
        end
    end

    // Outputs are registered or decoded from state only.
    always_comb begin
        busy_o = (state_q == WORK);
        y_bo   = y_q;
    end

endmodule : mult

// File: tb/tb_mult.sv
// Directed self-checking bench for the sequential multiplier.
module tb_mult;

    logic        clk;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        start;
    logic        busy;
    logic [15:0] y;

    int total = 0;
    int bad   = 0;

    mult u_dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .a_bi    (a),
        .b_bi    (b),
        .start_i (start),
        .busy_o  (busy),
        .y_bo    (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and count clocks of busy; no checking here.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          output int lat, output logic [15:0] res, output bit y_moved);
        logic [15:0] y_prev;
        @(posedge clk); #1;
        a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = $urandom_range(0, 255); b = $urandom_range(0, 255);
        y_prev  = y;
        y_moved = 1'b0;
        lat = 0;
        while (busy && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (busy && y !== y_prev) y_moved = 1'b1;
        end
        res = y;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) begin
            a = $urandom_range(0, 255); b = $urandom_range(0, 255);
            start = $urandom_range(0, 1);
            @(posedge clk); #1;
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (y !== 16'h0000) begin bad++; $display("FAIL reset_y got=%h want=0000", y); end
        start = 1'b0;
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_square();
        int lat; logic [15:0] res; bit moved;
        run_op(8'd8, 8'd8, lat, res, moved);
        total++; if (lat !== 8) begin bad++; $display("FAIL square_latency got=%0d want=8", lat); end
        total++; if (res !== 16'h0040) begin bad++; $display("FAIL square_y got=%h want=0040", res); end
        total++; if (moved) begin bad++; $display("FAIL square_y_stable got=changed want=stable"); end
        repeat (3) @(posedge clk); #1;
        total++; if (y !== 16'h0040 || busy !== 1'b0) begin
            bad++; $display("FAIL square_hold got=%h busy=%0b want=0040 busy=0", y, busy);
        end
    endtask

    task automatic test_extremes();
        logic [7:0]  av [3] = '{8'd255, 8'd0,   8'd1};
        logic [7:0]  bv [3] = '{8'd255, 8'd200, 8'd173};
        logic [15:0] ev [3] = '{16'hFE01, 16'h0000, 16'd173};
        int lat; logic [15:0] res; bit moved;
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], lat, res, moved);
            total++; if (lat !== 8) begin bad++; $display("FAIL extreme%0d_latency got=%0d want=8", i, lat); end
            total++; if (res !== ev[i]) begin bad++; $display("FAIL extreme%0d_y got=%h want=%h", i, res, ev[i]); end
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        @(posedge clk); #1;
        a = 8'd12; b = 8'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (busy && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 3) begin a = 8'd99; b = 8'd77; start = 1'b1; end
            if (lat == 4) start = 1'b0;
        end
        total++; if (lat !== 8) begin bad++; $display("FAIL busy_start_latency got=%0d want=8", lat); end
        total++; if (y !== 16'd120) begin bad++; $display("FAIL busy_start_y got=%0d want=120", y); end
    endtask

    task automatic test_midop_reset();
        int lat; logic [15:0] res; bit moved;
        @(posedge clk); #1;
        a = 8'd200; b = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%0b want=0", busy); end
        total++; if (y !== 16'h0000) begin bad++; $display("FAIL midreset_y got=%h want=0000", y); end
        @(negedge clk); rst = 1'b1;
        run_op(8'd13, 8'd11, lat, res, moved);
        total++; if (lat !== 8) begin bad++; $display("FAIL after_reset_latency got=%0d want=8", lat); end
        total++; if (res !== 16'd143) begin bad++; $display("FAIL after_reset_y got=%0d want=143", res); end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        a = 8'd3; b = 8'd5; start = 1'b1;
        @(posedge clk); #1;
        a = 8'd7; b = 8'd9;
        for (int k = 1; k <= 17; k++) begin
            @(posedge clk); #1;
            if (k == 8) begin
                total++; if (y !== 16'd15) begin bad++; $display("FAIL b2b_first_y got=%0d want=15", y); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_first_busy got=%0b want=0", busy); end
            end
            if (k == 9) begin
                start = 1'b0;
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_restart_busy got=%0b want=1", busy); end
            end
            if (k == 16) begin
                total++; if (busy !== 1'b1 || y !== 16'd15) begin
                    bad++; $display("FAIL b2b_second_pending got=%0d busy=%0b want=15 busy=1", y, busy);
                end
            end
            if (k == 17) begin
                total++; if (y !== 16'd63) begin bad++; $display("FAIL b2b_second_y got=%0d want=63", y); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_second_busy got=%0b want=0", busy); end
            end
        end
    endtask

    initial begin
        a = '0; b = '0; start = 1'b0; rst = 1'b0;
        test_reset();
        test_square();
        test_extremes();
        test_start_while_busy();
        test_midop_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mult
